// File: rtl/rv_ctrl_fsm_hs.sv
// Multicycle RV32I control FSM with memory request/ready handshake, per-access
// wait timeout, optional LUI/AUIPC decode and a sticky trap state.
module rv_ctrl_fsm_hs #(
  parameter int ALU_W       = 4,
  parameter int IMM_W       = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int UPPER_EN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             t_branch,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             addrsrc_ctrl,
  output logic             pc_write,
  output logic             pc_write_ctrl,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             reg_write,
  output logic [1:0]       regwrite_ctrl,
  output logic [IMM_W-1:0] imm_ctrl,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [1:0]       alu_in1_ctrl,
  output logic             alu_in2_ctrl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EX   = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_TRAP = 3'b101
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [IMM_W-1:0] IMM_I = IMM_W'(3'b000);
  localparam logic [IMM_W-1:0] IMM_S = IMM_W'(3'b001);
  localparam logic [IMM_W-1:0] IMM_B = IMM_W'(3'b011);
  localparam logic [IMM_W-1:0] IMM_J = IMM_W'(3'b100);
  localparam logic [IMM_W-1:0] IMM_U = IMM_W'(3'b101);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam bit TIMEOUT_ON = (MEM_TIMEOUT > 0);
  localparam bit UPPER_ON   = (UPPER_EN != 0);
  localparam int CNT_W      = TIMEOUT_ON ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_ON ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [1:0]       r_trap_cause;

  state_t           w_next;
  logic             w_mem_req, w_mem_write, w_addrsrc, w_pc_write, w_pc_write_ctrl;
  logic             w_ir_write, w_mdr_write, w_reg_write, w_alu_in2, w_trap;
  logic [1:0]       w_regwrite_ctrl, w_alu_in1;
  logic [IMM_W-1:0] w_imm;
  logic [ALU_W-1:0] w_alu;
  logic             w_illegal, w_cause_set, w_waiting, w_timeout;
  logic [1:0]       w_cause;

  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = TIMEOUT_ON && w_waiting && (r_wait_cnt == CNT_LIMIT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_next          = r_state;
    w_mem_req       = 1'b0;
    w_mem_write     = 1'b0;
    w_addrsrc       = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_ctrl = 1'b0;
    w_ir_write      = 1'b0;
    w_mdr_write     = 1'b0;
    w_reg_write     = 1'b0;
    w_regwrite_ctrl = 2'b00;
    w_imm           = IMM_I;
    w_alu           = '0;
    w_alu_in1       = 2'b00;
    w_alu_in2       = 1'b0;
    w_trap          = 1'b0;
    w_illegal       = 1'b0;
    w_cause_set     = 1'b0;
    w_cause         = 2'b00;

    case (r_state)
      S_IF: begin
        w_mem_req  = 1'b1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next = S_ID;
      end
      S_ID: begin
        // Branch target PC + imm B is precomputed here for a taken branch in EX.
        w_alu_in1 = 2'b01;
        w_alu_in2 = 1'b1;
        w_imm     = IMM_B;
        w_next    = S_EX;
      end
      S_EX: begin
        w_next = S_WB;
        case (opcode)
          OP_R: w_alu = ALU_W'({funct7[5], funct3});
          OP_I: begin
            w_alu_in2 = 1'b1;
            w_alu     = ALU_W'({funct7[5] & (funct3 == 3'b101), funct3});
          end
          OP_LOAD, OP_STORE: begin
            w_alu_in2 = 1'b1;
            w_imm     = (opcode == OP_STORE) ? IMM_S : IMM_I;
            w_next    = S_MEM;
          end
          OP_JALR: w_alu_in2 = 1'b1;
          OP_JAL: begin
            w_alu_in1 = 2'b01;
            w_alu_in2 = 1'b1;
            w_imm     = IMM_J;
          end
          OP_LUI, OP_AUIPC: begin
            if (UPPER_ON) begin
              w_alu_in1 = (opcode == OP_LUI) ? 2'b10 : 2'b01;
              w_alu_in2 = 1'b1;
              w_imm     = IMM_U;
            end else begin
              w_illegal = 1'b1;
            end
          end
          OP_BRANCH: begin
            w_next = S_IF;
            case (funct3)
              3'b000:  w_alu = ALU_W'(4'b1010);
              3'b001:  w_alu = ALU_W'(4'b1011);
              3'b100:  w_alu = ALU_W'(4'b1100);
              3'b101:  w_alu = ALU_W'(4'b1101);
              3'b110:  w_alu = ALU_W'(4'b1110);
              3'b111:  w_alu = ALU_W'(4'b1111);
              default: w_illegal = 1'b1;
            endcase
            if (!w_illegal) begin
              w_pc_write      = t_branch;
              w_pc_write_ctrl = t_branch;
            end
          end
          default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
          w_next      = S_TRAP;
          w_cause_set = 1'b1;
          w_cause     = CAUSE_ILLEGAL;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_addrsrc = 1'b1;
        if (opcode == OP_STORE) begin
          w_mem_write = 1'b1;
          if (mem_ready) w_next = S_IF;
        end else begin
          w_mdr_write = mem_ready;
          if (mem_ready) w_next = S_WB;
        end
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_IF;
        case (opcode)
          OP_LOAD: w_regwrite_ctrl = 2'b01;
          OP_JAL, OP_JALR: begin
            w_regwrite_ctrl = 2'b10;
            w_pc_write      = 1'b1;
            w_pc_write_ctrl = 1'b1;
          end
          default: w_regwrite_ctrl = 2'b00;
        endcase
      end
      S_TRAP:  w_trap = 1'b1;
      default: w_next = S_IF;
    endcase

    // A ready in the limit cycle has already moved w_next on, so it wins.
    if (w_timeout && !mem_ready) begin
      w_next      = S_TRAP;
      w_cause_set = 1'b1;
      w_cause     = CAUSE_TIMEOUT;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IF;
      r_wait_cnt   <= '0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_waiting && (r_wait_cnt != CNT_MAX))
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_cause_set)
        r_trap_cause <= w_cause;
    end
  end

  // NOTE: outputs are gated by rst so they drop the moment reset asserts, not at the next edge.
  assign mem_req       = rst ? w_mem_req       : 1'b0;
  assign mem_write     = rst ? w_mem_write     : 1'b0;
  assign addrsrc_ctrl  = rst ? w_addrsrc       : 1'b0;
  assign pc_write      = rst ? w_pc_write      : 1'b0;
  assign pc_write_ctrl = rst ? w_pc_write_ctrl : 1'b0;
  assign ir_write      = rst ? w_ir_write      : 1'b0;
  assign mdr_write     = rst ? w_mdr_write     : 1'b0;
  assign reg_write     = rst ? w_reg_write     : 1'b0;
  assign regwrite_ctrl = rst ? w_regwrite_ctrl : 2'b00;
  assign imm_ctrl      = rst ? w_imm           : '0;
  assign alu_ctrl      = rst ? w_alu           : '0;
  assign alu_in1_ctrl  = rst ? w_alu_in1       : 2'b00;
  assign alu_in2_ctrl  = rst ? w_alu_in2       : 1'b0;
  assign trap          = rst ? w_trap          : 1'b0;
  assign trap_cause    = rst ? r_trap_cause    : 2'b00;
  assign state_o       = rst ? r_state         : 3'b000;

endmodule

// File: tb/tb_rv_ctrl_fsm_hs.sv
// Directed bench for rv_ctrl_fsm_hs: instance a uses default parameters,
// instance b uses MEM_TIMEOUT=4 and UPPER_EN=0; both share inputs.
module tb_rv_ctrl_fsm_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic       t_branch = 1'b0;
  logic       mem_ready = 1'b0;

  logic       a_mem_req, a_mem_write, a_addrsrc, a_pc_write, a_pc_write_ctrl;
  logic       a_ir_write, a_mdr_write, a_reg_write, a_alu_in2, a_trap;
  logic [1:0] a_regwrite_ctrl, a_alu_in1, a_trap_cause;
  logic [2:0] a_imm, a_state;
  logic [3:0] a_alu;

  logic       b_mem_req, b_mem_write, b_addrsrc, b_pc_write, b_pc_write_ctrl;
  logic       b_ir_write, b_mdr_write, b_reg_write, b_alu_in2, b_trap;
  logic [1:0] b_regwrite_ctrl, b_alu_in1, b_trap_cause;
  logic [2:0] b_imm, b_state;
  logic [3:0] b_alu;

  int checks = 0;
  int errors = 0;
  logic [31:0] got, exp;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  rv_ctrl_fsm_hs dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .t_branch(t_branch), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_write(a_mem_write), .addrsrc_ctrl(a_addrsrc),
    .pc_write(a_pc_write), .pc_write_ctrl(a_pc_write_ctrl), .ir_write(a_ir_write),
    .mdr_write(a_mdr_write), .reg_write(a_reg_write), .regwrite_ctrl(a_regwrite_ctrl),
    .imm_ctrl(a_imm), .alu_ctrl(a_alu), .alu_in1_ctrl(a_alu_in1), .alu_in2_ctrl(a_alu_in2),
    .trap(a_trap), .trap_cause(a_trap_cause), .state_o(a_state)
  );

  rv_ctrl_fsm_hs #(.MEM_TIMEOUT(4), .UPPER_EN(0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .t_branch(t_branch), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_write(b_mem_write), .addrsrc_ctrl(b_addrsrc),
    .pc_write(b_pc_write), .pc_write_ctrl(b_pc_write_ctrl), .ir_write(b_ir_write),
    .mdr_write(b_mdr_write), .reg_write(b_reg_write), .regwrite_ctrl(b_regwrite_ctrl),
    .imm_ctrl(b_imm), .alu_ctrl(b_alu), .alu_in1_ctrl(b_alu_in1), .alu_in2_ctrl(b_alu_in2),
    .trap(b_trap), .trap_cause(b_trap_cause), .state_o(b_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    funct3 = f3;
    funct7 = f7;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    t_branch = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic run_to_ex();
    mem_ready = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    set_instr(OP_R, 3'b000, 7'b0);
    rst = 1'b0;
    mem_ready = 1'b1;
    step();
    @(negedge clk);
    got = 32'({a_state, a_mem_req, a_ir_write, a_pc_write, a_trap, a_trap_cause});
    exp = 32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_hold_a got %h want %h", got, exp); end
    got = 32'({b_state, b_mem_req, b_ir_write, b_trap_cause});
    exp = 32'({3'd0, 1'b0, 1'b0, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_hold_b got %h want %h", got, exp); end
    step();
    rst = 1'b1;
    #1;
    got = 32'({a_state, a_mem_req, a_addrsrc, a_ir_write, a_pc_write});
    exp = 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release got %h want %h", got, exp); end
  endtask

  task automatic test_add();
    do_reset();
    set_instr(OP_R, 3'b000, 7'b0);
    mem_ready = 1'b1;
    @(negedge clk);
    got = 32'({a_state, a_mem_req, a_addrsrc, a_ir_write, a_pc_write, a_pc_write_ctrl});
    exp = 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_if got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm, a_alu, a_mem_req});
    exp = 32'({3'd1, 2'b01, 1'b1, 3'b011, 4'b0000, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_id got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_alu, a_reg_write});
    exp = 32'({3'd2, 2'b00, 1'b0, 4'b0000, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_ex got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_reg_write, a_regwrite_ctrl, a_alu, a_pc_write});
    exp = 32'({3'd4, 1'b1, 2'b00, 4'b0000, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL add_wb got %h want %h", got, exp); end
    step();
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL add_done got %h want 0", a_state); end
  endtask

  task automatic test_alu_decode();
    logic [6:0] t_op  [5] = '{OP_R, OP_R, OP_I, OP_I, OP_I};
    logic [2:0] t_f3  [5] = '{3'b000, 3'b101, 3'b101, 3'b000, 3'b110};
    logic [6:0] t_f7  [5] = '{7'b0100000, 7'b0100000, 7'b0100000, 7'b0100000, 7'b0000000};
    logic [3:0] t_alu [5] = '{4'b1000, 4'b1101, 4'b1101, 4'b0000, 4'b0110};
    logic       t_in2 [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      do_reset();
      set_instr(t_op[i], t_f3[i], t_f7[i]);
      run_to_ex();
      @(negedge clk);
      got = 32'({a_state, a_alu, a_alu_in2, a_imm});
      exp = 32'({3'd2, t_alu[i], t_in2[i], 3'b000});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_ex[%0d] got %h want %h", i, got, exp); end
      step();
      @(negedge clk);
      got = 32'({a_state, a_reg_write, a_regwrite_ctrl});
      exp = 32'({3'd4, 1'b1, 2'b00});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_wb[%0d] got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    set_instr(OP_LOAD, 3'b010, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm, a_alu, a_mem_req});
    exp = 32'({3'd2, 2'b00, 1'b1, 3'b000, 4'b0000, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_ex got %h want %h", got, exp); end
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = 32'({a_state, a_mem_req, a_addrsrc, a_mdr_write, a_mem_write});
      exp = 32'({3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL lw_wait[%0d] got %h want %h", i, got, exp); end
      step();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    got = 32'({a_state, a_mem_req, a_addrsrc, a_mdr_write, a_mem_write});
    exp = 32'({3'd3, 1'b1, 1'b1, 1'b1, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_ready got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_reg_write, a_regwrite_ctrl, a_mem_req});
    exp = 32'({3'd4, 1'b1, 2'b01, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_wb got %h want %h", got, exp); end
    step();
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL lw_done got %h want 0", a_state); end
  endtask

  task automatic test_store_reset();
    do_reset();
    set_instr(OP_STORE, 3'b010, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in2, a_imm, a_mem_write});
    exp = 32'({3'd2, 1'b1, 3'b001, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_ex got %h want %h", got, exp); end
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      got = 32'({a_state, a_mem_req, a_mem_write, a_addrsrc, a_mdr_write});
      exp = 32'({3'd3, 1'b1, 1'b1, 1'b1, 1'b0});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sw_wait[%0d] got %h want %h", i, got, exp); end
      if (i == 0) step();
    end
    rst = 1'b0;
    #1;
    got = 32'({a_state, a_mem_req, a_mem_write, a_addrsrc, a_trap, a_trap_cause});
    exp = 32'({3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_async_rst got %h want %h", got, exp); end
    step();
    rst = 1'b1;
    #1;
    got = 32'({a_state, a_mem_req, a_addrsrc, a_mem_write});
    exp = 32'({3'd0, 1'b1, 1'b0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_rst_release got %h want %h", got, exp); end
    mem_ready = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    got = 32'({a_state, a_mem_req, a_mem_write});
    exp = 32'({3'd3, 1'b1, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw_mem got %h want %h", got, exp); end
    step();
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL sw_done got %h want 0", a_state); end
  endtask

  task automatic test_branch();
    logic [2:0] t_f3  [4] = '{3'b000, 3'b000, 3'b001, 3'b111};
    logic       t_tkn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] t_alu [4] = '{4'b1010, 4'b1010, 4'b1011, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      do_reset();
      set_instr(OP_BRANCH, t_f3[i], 7'b0);
      t_branch = t_tkn[i];
      run_to_ex();
      @(negedge clk);
      got = 32'({a_state, a_alu, a_pc_write, a_pc_write_ctrl, a_alu_in1, a_alu_in2});
      exp = 32'({3'd2, t_alu[i], t_tkn[i], t_tkn[i], 2'b00, 1'b0});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL br_ex[%0d] got %h want %h", i, got, exp); end
      step();
      @(negedge clk);
      checks++;
      if (a_state !== 3'd0) begin errors++; $display("FAIL br_next[%0d] got %h want 0", i, a_state); end
    end
    do_reset();
    set_instr(OP_BRANCH, 3'b010, 7'b0);
    t_branch = 1'b1;
    run_to_ex();
    @(negedge clk);
    checks++;
    if (a_pc_write !== 1'b0) begin errors++; $display("FAIL br_illegal_pcw got %h want 0", a_pc_write); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_trap, a_trap_cause, a_mem_req});
    exp = 32'({3'd5, 1'b1, 2'b01, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL br_illegal got %h want %h", got, exp); end
  endtask

  task automatic test_jump();
    do_reset();
    set_instr(OP_JAL, 3'b000, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm});
    exp = 32'({3'd2, 2'b01, 1'b1, 3'b100});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL jal_ex got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_reg_write, a_regwrite_ctrl, a_pc_write, a_pc_write_ctrl});
    exp = 32'({3'd4, 1'b1, 2'b10, 1'b1, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL jal_wb got %h want %h", got, exp); end
    do_reset();
    set_instr(OP_JALR, 3'b000, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm});
    exp = 32'({3'd2, 2'b00, 1'b1, 3'b000});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL jalr_ex got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_reg_write, a_regwrite_ctrl, a_pc_write, a_pc_write_ctrl});
    exp = 32'({3'd4, 1'b1, 2'b10, 1'b1, 1'b1});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL jalr_wb got %h want %h", got, exp); end
  endtask

  task automatic test_upper();
    do_reset();
    set_instr(OP_LUI, 3'b000, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm});
    exp = 32'({3'd2, 2'b10, 1'b1, 3'b101});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lui_ex got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_reg_write, a_regwrite_ctrl});
    exp = 32'({3'd4, 1'b1, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lui_wb got %h want %h", got, exp); end
    got = 32'({b_state, b_trap, b_trap_cause, b_reg_write});
    exp = 32'({3'd5, 1'b1, 2'b01, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lui_disabled got %h want %h", got, exp); end
    do_reset();
    set_instr(OP_AUIPC, 3'b000, 7'b0);
    run_to_ex();
    @(negedge clk);
    got = 32'({a_state, a_alu_in1, a_alu_in2, a_imm});
    exp = 32'({3'd2, 2'b01, 1'b1, 3'b101});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL auipc_ex got %h want %h", got, exp); end
    do_reset();
    set_instr(7'b1111111, 3'b000, 7'b0);
    run_to_ex();
    step();
    @(negedge clk);
    got = 32'({a_state, a_trap, a_trap_cause, a_mem_req});
    exp = 32'({3'd5, 1'b1, 2'b01, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL bad_opcode got %h want %h", got, exp); end
    step();
    step();
    @(negedge clk);
    got = 32'({a_state, a_trap, a_trap_cause, a_mem_req, a_ir_write});
    exp = 32'({3'd5, 1'b1, 2'b01, 1'b0, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL trap_sticky got %h want %h", got, exp); end
  endtask

  task automatic test_timeout();
    do_reset();
    set_instr(OP_R, 3'b000, 7'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = 32'({b_state, b_mem_req, b_ir_write, b_trap});
      exp = 32'({3'd0, 1'b1, 1'b0, 1'b0});
      checks++;
      if (got !== exp) begin errors++; $display("FAIL to_if[%0d] got %h want %h", i, got, exp); end
      step();
    end
    @(negedge clk);
    got = 32'({b_state, b_trap, b_trap_cause, b_mem_req});
    exp = 32'({3'd5, 1'b1, 2'b10, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_trap got %h want %h", got, exp); end
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL to_a_still_if got %h want 0", a_state); end
    mem_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    got = 32'({b_state, b_trap, b_trap_cause, b_mem_req});
    exp = 32'({3'd5, 1'b1, 2'b10, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_late_ready got %h want %h", got, exp); end
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    got = 32'({b_state, b_trap, b_trap_cause, b_mem_req});
    exp = 32'({3'd0, 1'b0, 2'b00, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_rst got %h want %h", got, exp); end
    step();
    rst = 1'b1;
    #1;
    got = 32'({b_state, b_mem_req, b_trap_cause});
    exp = 32'({3'd0, 1'b1, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_recover got %h want %h", got, exp); end
    do_reset();
    step();
    step();
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    got = 32'({b_state, b_ir_write, b_trap});
    exp = 32'({3'd0, 1'b1, 1'b0});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_limit_ready got %h want %h", got, exp); end
    step();
    @(negedge clk);
    got = 32'({b_state, b_trap_cause});
    exp = 32'({3'd1, 2'b00});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to_limit_next got %h want %h", got, exp); end
    do_reset();
    for (int i = 0; i < 15; i++) step();
    @(negedge clk);
    checks++;
    if (a_state !== 3'd0) begin errors++; $display("FAIL to16_edge got %h want 0", a_state); end
    step();
    @(negedge clk);
    got = 32'({a_state, a_trap_cause});
    exp = 32'({3'd5, 2'b10});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL to16_trap got %h want %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_decode();
    test_load_wait();
    test_store_reset();
    test_branch();
    test_jump();
    test_upper();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_ctrl_fsm_hs.md
Name: rv_ctrl_fsm_hs

Overview:
- Next-generation multicycle RV32I control FSM for the datapath (PC, IR, MDR, regfile, ALU, immediate generator).
- Adds over the current FSM:
  - a memory request/ready handshake with wait states on fetch and data access;
  - a per-access timeout counter;
  - optional LUI/AUIPC support;
  - a sticky illegal-instruction/bus-timeout trap state.
- Sits between the IR decode fields and all datapath enables/muxes.

Parameters:
- ALU_W, 4, width of alu_ctrl.
- IMM_W, 3, width of imm_ctrl.
- MEM_TIMEOUT, 16, max wait cycles per memory access. 0 disables the timeout.
- UPPER_EN, 1, 1 = decode LUI (0110111) and AUIPC (0010111). 0 = treat them as illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- t_branch  in  1  branch-taken flag from ALU compare.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  store strobe, valid with mem_req.
- addrsrc_ctrl  out  1  0 = PC address, 1 = ALU result address.
- pc_write  out  1  PC load enable.
- pc_write_ctrl  out  1  0 = PC+4 source, 1 = ALU/target source.
- ir_write  out  1  IR load enable.
- mdr_write  out  1  MDR load enable.
- reg_write  out  1  regfile write enable.
- regwrite_ctrl  out  2  00 = ALU, 01 = MDR, 10 = PC+4.
- imm_ctrl  out  IMM_W  000 = I, 001 = S, 011 = B, 100 = J, 101 = U.
- alu_ctrl  out  ALU_W  ALU operation; encoding unchanged from current ALU.
- alu_in1_ctrl  out  2  00 = rs1, 01 = old PC, 10 = zero.
- alu_in2_ctrl  out  1  0 = rs2, 1 = immediate.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout; registered.
- state_o  out  3  current state, for debug.

Behaviour:
- States: IF=000, ID=001, EX=010, MEM=011, WB=100, TRAP=101.
- Reset (rst low, async):
  - state = IF, wait counter = 0, trap_cause = 00.
  - While rst is low, every output is forced 0 (including mem_req).
- Defaults: all outputs 0 unless listed below.
- IF:
  - mem_req = 1, addrsrc_ctrl = 0.
  - ir_write = pc_write = mem_ready.
  - mem_ready = 1 → ID; else stay.
- ID:
  - alu_in1_ctrl = 01, alu_in2_ctrl = 1, imm_ctrl = 011, alu_ctrl = 0 (branch target precompute).
  - → EX.
- EX, decode by opcode:
  - R-type (0110011): rs1/rs2, alu_ctrl = {funct7[5], funct3} → WB.
  - I-ALU (0010011): rs1/imm I, alu_ctrl = {funct7[5] & (funct3==101), funct3} → WB.
  - Load (0000011): rs1 + imm I → MEM.
  - Store (0100011): rs1 + imm S → MEM.
  - JALR (1100111): rs1 + imm I → WB.
  - JAL (1101111): old PC + imm J → WB.
  - LUI: zero + imm U → WB. AUIPC: old PC + imm U → WB. Both only when UPPER_EN = 1.
  - Branch (1100011):
    - rs1/rs2 compare; alu_ctrl = 1010/1011/1100/1101/1110/1111 for funct3 000/001/100/101/110/111.
    - Other funct3 is illegal.
    - pc_write = pc_write_ctrl = t_branch.
    - → IF.
  - Any other opcode: → TRAP, trap_cause ← 01.
- MEM:
  - mem_req = 1, addrsrc_ctrl = 1.
  - Store: mem_write = 1, held every wait cycle. On mem_ready → IF.
  - Load: mdr_write = mem_ready. On mem_ready → WB.
- WB:
  - reg_write = 1.
  - regwrite_ctrl = 00 for R/I/LUI/AUIPC, 01 for load, 10 for JAL/JALR.
  - JAL/JALR additionally assert pc_write = pc_write_ctrl = 1.
  - → IF.
- TRAP:
  - trap = 1, all strobes 0.
  - Sticky until reset; trap_cause holds its value.
- Wait counter:
  - Clears on every state entry.
  - Increments each IF/MEM cycle with mem_ready = 0.
  - If MEM_TIMEOUT > 0, counter == MEM_TIMEOUT-1 and mem_ready = 0: → TRAP, trap_cause ← 10.
  - mem_ready in the limit cycle wins over the timeout (normal transition).
  - Counter width is clog2(MEM_TIMEOUT+1) and must not wrap.
- Timing:
  - Control outputs are combinational from state and inputs; state and trap_cause are registered.
  - Latency with zero-wait memory: branch 3, ALU/jump/upper 4, store 4, load 5 cycles.
  - Each wait cycle adds 1.
- Reset mid-access: immediate return to IF, mem_req drops in the same cycle.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied 1 → IF/ID/EX/WB in 4 cycles; WB shows reg_write = 1, regwrite_ctrl = 00, alu_ctrl = 0000.
- LW with mem_ready low for 3 cycles in MEM → mem_req = 1 held for 4 cycles; mdr_write = 1 only in the ready cycle; WB regwrite_ctrl = 01; total 8 cycles.
- BEQ taken (t_branch = 1) vs not taken → EX: alu_ctrl = 1010 with pc_write = pc_write_ctrl = 1 vs 0; next state IF both cases.
- MEM_TIMEOUT = 4, fetch with mem_ready stuck 0 → after 4 IF cycles state = TRAP, trap = 1, trap_cause = 10; ready arriving later has no effect; rst low recovers to IF.
- LUI with UPPER_EN = 1 → alu_in1_ctrl = 10, imm_ctrl = 101, reg_write in WB. Same with UPPER_EN = 0, or opcode 1111111 → TRAP, trap_cause = 01.
- Assert rst low mid-MEM of a store → all outputs 0 asynchronously; after release state_o = 000, mem_req = 1.
